apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_master_ctrl_if.sv | 42 ++++
 rtl/apb_addr_decoder.sv | 26 ++
 rtl/apb_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master controller: FSM states, default sizing, slave address map.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Slave i occupies the 4 KB page at SLV_BASE0 + i*0x1000. Decoding therefore only needs to look at
// address bits [31:12] and compare them against the page number of each slave.
package apb_pkg;

  localparam int unsigned DEF_NUM_SLV = 4;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Base address of slave 0. Later slaves follow at a 4 KB stride.
  localparam logic [31:0] SLV_BASE0   = 32'h1000_0000;
  localparam logic [19:0] SLV_PAGE0   = SLV_BASE0[31:12];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Page number (address bits [31:12]) that selects slave idx.
  function automatic logic [19:0] slv_page(input int unsigned idx);
    return SLV_PAGE0 + idx[19:0];
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundles the requester handshake and the APB bus of the controller into one port.
// Latency: n/a (wires only).
// Backpressure: requester holds transfer until ready; APB slaves stall through PREADY.
//
// Requester side : transfer, write, addr, wdata -> controller; rdata, ready, err <- controller.
// APB side       : PADDR, PWRITE, PENABLE, PWDATA, PSEL -> slaves; PRDATA, PREADY <- slaves.
// modport master : the controller's view.  modport slave : the requester + slaves' view.
interface apb_master_ctrl_if
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = DEF_NUM_SLV
) ();

  // requester handshake
  logic                        transfer;
  logic                        write;
  logic [31:0]                 addr;
  logic [31:0]                 wdata;
  logic [31:0]                 rdata;
  logic                        ready;
  logic                        err;

  // APB bus
  logic [31:0]                 PADDR;
  logic                        PWRITE;
  logic                        PENABLE;
  logic [31:0]                 PWDATA;
  logic [NUM_SLV-1:0]          PSEL;
  logic [NUM_SLV-1:0][31:0]    PRDATA;
  logic [NUM_SLV-1:0]          PREADY;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps an address page to a one-hot slave select, flagging pages that hit no slave.
// Latency: combinational.
// Backpressure: none.
//
// Ports: addr     - address bits [31:12] (the page number; page offset is irrelevant here)
//        sel      - one-hot select, all zero when unmapped
//        unmapped - high when no slave owns the page
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = DEF_NUM_SLV
) (
  input  logic [31:12]        addr,
  output logic [NUM_SLV-1:0]  sel,
  output logic                unmapped
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel[i] = (addr == slv_page(i));
    end
    unmapped = ~|sel;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: turns single held requests into SETUP/ACCESS bus cycles with wait-state timeout.
// Latency: ready two cycles after transfer is sampled in IDLE with a zero-wait slave.
// Backpressure: requester holds transfer until ready; PREADY low stretches ACCESS up to TIMEOUT cycles.
//
// Ports: PCLK   - clock
//        PRESET - synchronous reset, active low
//        bus    - apb_master_ctrl_if.master (requester handshake + APB bus)
// The interface instance must be built with the same NUM_SLV as this module.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = DEF_NUM_SLV,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_ctrl_if.master    bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;

  // registered request; drives the APB address/data phase unchanged until completion
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;
  logic                pwrite_q;
  logic [CNT_W-1:0]    wait_q;

  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_unmapped;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;

  // FSM control / outputs
  logic                load_req;
  logic                wait_clr;
  logic                wait_inc;
  logic                psel_en;
  logic                penable;
  logic                done;
  logic                done_err;
  logic [31:0]         done_rdata;

  // Decode from the registered address so PSEL stays stable for the whole transfer.
  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV)
  ) u_dec (
    .addr     (paddr_q[31:12]),
    .sel      (dec_sel),
    .unmapped (dec_unmapped)
  );

  // Only the selected slave's PREADY/PRDATA matter; the select is one-hot so an AND-OR mux suffices.
  assign sel_ready = |(bus.PREADY & dec_sel);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel_rdata = sel_rdata | ({32{dec_sel[i]}} & bus.PRDATA[i]);
    end
  end

  assign timeout_hit = (wait_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    load_req   = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    psel_en    = 1'b0;
    penable    = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;

    case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          load_req = 1'b1;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        psel_en  = 1'b1;
        wait_clr = 1'b1;
        state_d  = ACCESS;
      end

      ACCESS: begin
        psel_en = 1'b1;
        penable = 1'b1;
        // A completion strobe is suppressed in a reset cycle: the transfer is being aborted.
        // PREADY wins over a simultaneous timeout, so that case completes without error.
        if (PRESET && (dec_unmapped || sel_ready || timeout_hit)) begin
          done     = 1'b1;
          done_err = dec_unmapped || !sel_ready;
          if (!dec_unmapped && sel_ready && !pwrite_q) begin
            done_rdata = sel_rdata;
          end
          // Back-to-back: a request already waiting goes straight to SETUP.
          if (bus.transfer) begin
            load_req = 1'b1;
            state_d  = SETUP;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          wait_inc = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_req) begin
        paddr_q  <= bus.addr;
        pwdata_q <= bus.wdata;
        pwrite_q <= bus.write;
      end
      if (wait_clr) begin
        wait_q <= '0;
      end else if (wait_inc) begin
        wait_q <= wait_q + CNT_W'(1);
      end
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PENABLE = penable;
  assign bus.PSEL    = psel_en ? dec_sel : '0;

  assign bus.ready   = done;
  assign bus.err     = done_err;
  assign bus.rdata   = done_rdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  localparam int NSLV = 4;
  localparam int TMO  = 16;

  logic PCLK = 1'b0;
  logic PRESET;

  always #5 PCLK = ~PCLK;

  apb_master_ctrl_if #(.NUM_SLV(NSLV)) bus ();

  apb_master_ctrl #(
    .NUM_SLV (NSLV),
    .TIMEOUT (TMO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester and slave stimulus ----------------
  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } req_t;

  req_t        req_q[$];
  bit          dir_mode;
  int          dir_stall;   // ACCESS cycles with PREADY low before it rises; <0 = never
  logic [31:0] dir_rd;
  bit          rst_req;
  int          acc_cnt;

  logic        s_ready, s_err, s_pen, s_pwrite;
  logic [31:0] s_rdata, s_paddr, s_pwdata;
  logic [3:0]  s_psel;

  task automatic present();
    bus.transfer = 1'b1;
    bus.addr     = req_q[0].a;
    bus.write    = req_q[0].w;
    bus.wdata    = req_q[0].d;
  endtask

  // One clock: drive slave responses after the edge, snapshot the outputs, then let the
  // requester react to ready (next request or release) before the following edge.
  task automatic cycle();
    @(posedge PCLK);
    #1;
    PRESET  = !rst_req;
    rst_req = 1'b0;
    if (bus.PENABLE && (bus.PSEL != '0)) acc_cnt++;
    else acc_cnt = 0;
    for (int i = 0; i < NSLV; i++) begin
      if (dir_mode) begin
        bus.PREADY[i] = (dir_stall >= 0) && (acc_cnt > dir_stall);
        bus.PRDATA[i] = dir_rd;
      end else begin
        bus.PREADY[i] = (i == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        bus.PRDATA[i] = $urandom;
      end
    end
    #1;
    s_ready  = bus.ready;   s_err    = bus.err;     s_rdata = bus.rdata;
    s_psel   = bus.PSEL;    s_pen    = bus.PENABLE; s_paddr = bus.PADDR;
    s_pwdata = bus.PWDATA;  s_pwrite = bus.PWRITE;
    if (bus.transfer && bus.ready) begin
      req_q.delete(0);
      if (req_q.size() > 0) present();
      else bus.transfer = 1'b0;
    end else if (!bus.transfer && req_q.size() > 0) begin
      present();
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks the transaction in flight as "cycles since the select phase began" (m_k):
  // m_k==0 is the select-only cycle, m_k>=1 are enable cycles, the TMO-th enable cycle times out.
  bit          cmp_on  = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_fresh = 1'b0;
  int          m_k;
  logic [31:0] m_a, m_d;
  logic        m_w;

  function automatic void expect_now(output logic rdy, output logic e, output logic [31:0] rd,
                                     output logic [3:0] ps, output logic pen);
    logic [19:0] page;
    bit          mapped;
    int          idx;
    rdy = 0; e = 0; rd = 0; ps = 0; pen = 0;
    if (m_busy) begin
      page   = m_a[31:12];
      mapped = (page >= 20'h10000) && (page < 20'h10000 + NSLV);
      idx    = int'(page - 20'h10000);
      if (mapped) ps = 4'(1 << idx);
      pen = (m_k >= 1);
      if (m_k >= 1 && PRESET === 1'b1) begin
        if (!mapped) begin
          rdy = 1; e = 1;
        end else if (bus.PREADY[idx]) begin
          rdy = 1;
          rd  = m_w ? 32'h0 : bus.PRDATA[idx];
        end else if (m_k == TMO) begin
          rdy = 1; e = 1;
        end
      end
    end
  endfunction

  always @(posedge PCLK) begin : model
    logic r, e, p;
    logic [31:0] rd;
    logic [3:0]  ps;
    expect_now(r, e, rd, ps, p);
    if (PRESET !== 1'b1) begin
      m_busy = 0; m_fresh = 1; m_a = 0; m_d = 0; m_w = 0; cmp_on = 1;
    end else if (!m_busy || r) begin
      if (bus.transfer) begin
        m_busy = 1; m_k = 0; m_fresh = 0;
        m_a = bus.addr; m_w = bus.write; m_d = bus.wdata;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_k++;
    end
  end

  always @(negedge PCLK) begin : compare
    logic r, e, p;
    logic [31:0] rd;
    logic [3:0]  ps;
    if (cmp_on) begin
      expect_now(r, e, rd, ps, p);
      chk("ready",   bus.ready,   r);
      chk("err",     bus.err,     e);
      chk("rdata",   bus.rdata,   rd);
      chk("psel",    bus.PSEL,    ps);
      chk("penable", bus.PENABLE, p);
      if (m_busy || m_fresh) begin
        chk("paddr",  bus.PADDR,  m_a);
        chk("pwdata", bus.PWDATA, m_d);
        chk("pwrite", bus.PWRITE, m_w);
      end
    end
  end

  // ---------------- directed scenarios with literal expectations ----------------
  logic [3:0]  h_psel[32];
  logic        h_pen[32], h_rdy[32], h_err[32];
  logic [31:0] h_rdata[32], h_paddr[32], h_pwdata[32];

  task automatic run_hist(input int n);
    for (int c = 0; c < n; c++) begin
      cycle();
      h_psel[c]  = s_psel;  h_pen[c]   = s_pen;   h_rdy[c]    = s_ready;
      h_err[c]   = s_err;   h_rdata[c] = s_rdata; h_paddr[c]  = s_paddr;
      h_pwdata[c] = s_pwdata;
    end
  endtask

  function automatic int first_ready(input int n);
    for (int c = 0; c < n; c++) if (h_rdy[c]) return c;
    return -1;
  endfunction

  function automatic int count_ready(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (h_rdy[c]) k++;
    return k;
  endfunction

  function automatic req_t rand_req();
    req_t        q;
    int          k;
    logic [19:0] pg;
    k = $urandom_range(0, 9);
    if (k < 6)       pg = 20'h10000 + 20'($urandom_range(0, NSLV - 1));
    else if (k == 6) pg = 20'h10000 + 20'(NSLV);      // first page past the last slave
    else if (k == 7) pg = 20'h0FFFF;                  // page just below slave 0
    else             pg = 20'($urandom);
    q.a = {pg, 12'($urandom)};
    q.w = 1'($urandom_range(0, 1));
    q.d = $urandom;
    return q;
  endfunction

  int fr;

  initial begin
    PRESET = 1'b0;
    bus.transfer = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.PREADY = '0;     bus.PRDATA = '0;
    dir_mode = 1'b1; dir_stall = 0; dir_rd = '0; acc_cnt = 0;

    // reset, then everything must read zero
    rst_req = 1'b1; cycle();
    rst_req = 1'b1; cycle();
    cycle();
    chk("rst_ready", s_ready, 0);   chk("rst_err", s_err, 0);     chk("rst_rdata", s_rdata, 0);
    chk("rst_psel", s_psel, 0);     chk("rst_pen", s_pen, 0);     chk("rst_paddr", s_paddr, 0);
    chk("rst_pwdata", s_pwdata, 0); chk("rst_pwrite", s_pwrite, 0);

    // zero-wait write to slave 1
    req_q.push_back('{32'h1000_1004, 1'b1, 32'h0000_000F});
    dir_stall = 0;
    run_hist(5);
    chk("zw_setup_psel", h_psel[1], 4'b0010);  chk("zw_setup_pen", h_pen[1], 0);
    chk("zw_setup_paddr", h_paddr[1], 32'h1000_1004); chk("zw_setup_pwdata", h_pwdata[1], 32'hF);
    chk("zw_acc_psel", h_psel[2], 4'b0010);    chk("zw_acc_pen", h_pen[2], 1);
    chk("zw_latency", 32'(first_ready(5)), 2); chk("zw_err", h_err[2], 0);
    chk("zw_rdata", h_rdata[2], 0);            chk("zw_nready", 32'(count_ready(5)), 1);
    chk("zw_idle_psel", h_psel[3], 0);

    // read from slave 2 with three wait states
    req_q.push_back('{32'h1000_2000, 1'b0, 32'h0});
    dir_stall = 3; dir_rd = 32'hA5A5_A5A5;
    run_hist(8);
    chk("ws_latency", 32'(first_ready(8)), 5); chk("ws_nready", 32'(count_ready(8)), 1);
    chk("ws_rdata", h_rdata[5], 32'hA5A5_A5A5); chk("ws_err", h_err[5], 0);
    chk("ws_wait_psel", h_psel[3], 4'b0100);   chk("ws_wait_pen", h_pen[3], 1);
    chk("ws_wait_rdata", h_rdata[4], 0);

    // unmapped read
    req_q.push_back('{32'h2000_0000, 1'b0, 32'h0});
    dir_stall = 0;
    run_hist(4);
    chk("um_latency", 32'(first_ready(4)), 2); chk("um_err", h_err[2], 1);
    chk("um_rdata", h_rdata[2], 0);
    chk("um_psel_setup", h_psel[1], 0);        chk("um_psel_acc", h_psel[2], 0);

    // timeout on slave 0
    req_q.push_back('{32'h1000_0000, 1'b0, 32'h0});
    dir_stall = -1;
    run_hist(20);
    chk("to_latency", 32'(first_ready(20)), 17); chk("to_nready", 32'(count_ready(20)), 1);
    chk("to_err", h_err[17], 1);               chk("to_rdata", h_rdata[17], 0);
    chk("to_idle_psel", h_psel[18], 0);        chk("to_idle_pen", h_pen[18], 0);

    // PREADY arriving on the would-be timeout cycle completes cleanly
    req_q.push_back('{32'h1000_0010, 1'b0, 32'h0});
    dir_stall = TMO - 1; dir_rd = 32'h1234_5678;
    run_hist(20);
    chk("tl_latency", 32'(first_ready(20)), 17); chk("tl_err", h_err[17], 0);
    chk("tl_rdata", h_rdata[17], 32'h1234_5678);

    // back-to-back writes with transfer held
    req_q.push_back('{32'h1000_1004, 1'b1, 32'h0000_000F});
    req_q.push_back('{32'h1000_1004, 1'b1, 32'h0000_0000});
    dir_stall = 0;
    run_hist(7);
    chk("b2b_first", 32'(first_ready(7)), 2);  chk("b2b_nready", 32'(count_ready(7)), 2);
    chk("b2b_pwdata1", h_pwdata[2], 32'hF);
    chk("b2b_setup2_psel", h_psel[3], 4'b0010); chk("b2b_setup2_pen", h_pen[3], 0);
    chk("b2b_pwdata2", h_pwdata[3], 32'h0);    chk("b2b_ready2", h_rdy[4], 1);
    chk("b2b_idle_psel", h_psel[5], 0);

    // reset in the middle of a wait state
    req_q.push_back('{32'h1000_0000, 1'b0, 32'h0});
    dir_stall = -1;
    run_hist(4);
    chk("ra_in_access", h_pen[3], 1);
    rst_req = 1'b1;
    cycle();
    chk("ra_no_ready", s_ready, 0);
    req_q.delete();
    bus.transfer = 1'b0;
    cycle();
    chk("ra_ready", s_ready, 0);   chk("ra_psel", s_psel, 0);     chk("ra_pen", s_pen, 0);
    chk("ra_paddr", s_paddr, 0);   chk("ra_err", s_err, 0);       chk("ra_rdata", s_rdata, 0);

    // randomized traffic, checked every cycle by the compare process
    dir_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0 && req_q.size() < 3) req_q.push_back(rand_req());
      if ($urandom_range(0, 249) == 0) rst_req = 1'b1;
      cycle();
    end
    for (int i = 0; i < 300 && req_q.size() > 0; i++) cycle();
    chk("drain", 32'(req_q.size()), 0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
